pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 51 +++++
 rtl/pipe_stage_slot.sv | 72 +++++++
 rtl/pipe_stage_reg.sv | 110 +++++++++++
 tb/tb_pipe_stage_reg.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared stage-boundary constants for the pipeline registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;

    // Control-bit indices per stage boundary
    localparam int IDEX_WE_REG  = 0;
    localparam int IDEX_WE_MEM  = 1;
    localparam int IDEX_WB_SEL  = 2;
    localparam int EXMEM_WE_REG = 0;
    localparam int EXMEM_WE_MEM = 1;
    localparam int EXMEM_WB_SEL = 2;
    localparam int MEMWB_WE_REG = 0;
    localparam int MEMWB_WB_SEL = 1;

    // Data-word layout, low field first: {rd, alu/pc, store/load/instr}
    localparam int DATA_LO_LSB = 0;
    localparam int DATA_HI_LSB = WORD_W;
    localparam int DATA_RD_LSB = 2 * WORD_W;

    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 2 * WORD_W;
    localparam int IDEX_CTRL_W  = 3;
    localparam int IDEX_DATA_W  = REG_ADDR_W + 2 * WORD_W;
    localparam int EXMEM_CTRL_W = 3;
    localparam int EXMEM_DATA_W = REG_ADDR_W + 2 * WORD_W;
    localparam int MEMWB_CTRL_W = 2;
    localparam int MEMWB_DATA_W = REG_ADDR_W + 2 * WORD_W;

    typedef enum logic [1:0] {
        SLOT_LOAD  = 2'd0,
        SLOT_HOLD  = 2'd1,
        SLOT_FLUSH = 2'd2
    } slot_op_e;

    function automatic slot_op_e slot_op(input logic stall, input logic flush);
        if (flush)      return SLOT_FLUSH;
        else if (stall) return SLOT_HOLD;
        else            return SLOT_LOAD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_slot.sv
// ============================================================================
// Module      : pipe_stage_slot
// Description : One valid/ctrl/data register slot, flush > stall > load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 3,
    parameter int DATA_W = 69
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    slot_op_e          w_op;
    logic              w_valid_d;
    logic [CTRL_W-1:0] w_ctrl_d;
    logic [DATA_W-1:0] w_data_d;
    logic              r_valid_q;
    logic [CTRL_W-1:0] r_ctrl_q;
    logic [DATA_W-1:0] r_data_q;

    always_comb begin
        w_op      = slot_op(stall, flush);
        w_valid_d = r_valid_q;
        w_ctrl_d  = r_ctrl_q;
        w_data_d  = r_data_q;
        case (w_op)
            SLOT_FLUSH: begin
                // Data is left in place; only valid/ctrl matter in a bubble.
                w_valid_d = 1'b0;
                w_ctrl_d  = '0;
            end
            SLOT_LOAD: begin
                w_valid_d = in_valid;
                w_ctrl_d  = in_valid ? in_ctrl : '0;
                w_data_d  = in_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_ctrl_q  <= '0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_ctrl_q  <= w_ctrl_d;
            r_data_q  <= w_data_d;
        end
    end

    assign out_valid = r_valid_q;
    assign out_ctrl  = r_ctrl_q;
    assign out_data  = r_data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : DEPTH-slot inter-stage pipeline register with stall/flush.
//               Optional counters under macro PIPE_STAGE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EXMEM_CTRL_W,
    parameter int DATA_W = EXMEM_DATA_W,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    if (DEPTH < 1) begin : g_depth_check
        $error("pipe_stage_reg: DEPTH must be at least 1");
    end
    if (CNT_W < 1) begin : g_cnt_check
        $error("pipe_stage_reg: CNT_W must be at least 1");
    end

    // Index 0 is the upstream input; index k is the output of slot k-1.
    logic              w_valid [0:DEPTH];
    logic [CTRL_W-1:0] w_ctrl  [0:DEPTH];
    logic [DATA_W-1:0] w_data  [0:DEPTH];

    assign w_valid[0] = in_valid;
    assign w_ctrl[0]  = in_ctrl;
    assign w_data[0]  = in_data;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        pipe_stage_slot #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (w_valid[k]),
            .in_ctrl   (w_ctrl[k]),
            .in_data   (w_data[k]),
            .stall     (stall),
            .flush     (flush),
            .out_valid (w_valid[k+1]),
            .out_ctrl  (w_ctrl[k+1]),
            .out_data  (w_data[k+1])
        );
    end

    assign out_valid = w_valid[DEPTH];
    assign out_ctrl  = w_ctrl[DEPTH];
    assign out_data  = w_data[DEPTH];

`ifdef PIPE_STAGE_STATS_EN
    logic             w_stall_evt;
    logic             w_bubble_evt;
    logic [CNT_W-1:0] w_stall_cnt_d;
    logic [CNT_W-1:0] w_bubble_cnt_d;
    logic [CNT_W-1:0] r_stall_cnt_q;
    logic [CNT_W-1:0] r_bubble_cnt_q;

    always_comb begin
        w_stall_evt    = stall & ~flush;
        // Last slot receives a bubble on flush, or on a shift of an invalid entry.
        w_bubble_evt   = flush | (~stall & ~w_valid[DEPTH-1]);
        w_stall_cnt_d  = r_stall_cnt_q;
        w_bubble_cnt_d = r_bubble_cnt_q;
        if (w_stall_evt && !(&r_stall_cnt_q)) begin
            w_stall_cnt_d = r_stall_cnt_q + CNT_W'(1);
        end
        if (w_bubble_evt && !(&r_bubble_cnt_q)) begin
            w_bubble_cnt_d = r_bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt_q  <= '0;
            r_bubble_cnt_q <= '0;
        end else begin
            r_stall_cnt_q  <= w_stall_cnt_d;
            r_bubble_cnt_q <= w_bubble_cnt_d;
        end
    end

    assign stall_cnt  = r_stall_cnt_q;
    assign bubble_cnt = r_bubble_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed bench; u1 is DEPTH=1/CNT_W=4, u2 is DEPTH=2/CNT_W=16.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    localparam int CW = 3;
    localparam int DW = 69;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;

    logic          o1_valid, o2_valid;
    logic [CW-1:0] o1_ctrl, o2_ctrl;
    logic [DW-1:0] o1_data, o2_data;
`ifdef PIPE_STAGE_STATS_EN
    logic [3:0]    s1_cnt, b1_cnt;
    logic [15:0]   s2_cnt, b2_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(1), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_data(in_data), .stall(stall), .flush(flush),
        .out_valid(o1_valid), .out_ctrl(o1_ctrl), .out_data(o1_data)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cnt(s1_cnt), .bubble_cnt(b1_cnt)
`endif
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(2), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_data(in_data), .stall(stall), .flush(flush),
        .out_valid(o2_valid), .out_ctrl(o2_ctrl), .out_data(o2_data)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cnt(s2_cnt), .bubble_cnt(b2_cnt)
`endif
    );

    // A bubble must never carry control bits.
    always @(negedge clk) begin
        n_cmp = n_cmp + 1;
        if (!o1_valid && o1_ctrl !== '0) begin
            n_fail = n_fail + 1;
            $display("FAIL invariant_u1: ctrl=%0h while invalid, required 0", o1_ctrl);
        end
        n_cmp = n_cmp + 1;
        if (!o2_valid && o2_ctrl !== '0) begin
            n_fail = n_fail + 1;
            $display("FAIL invariant_u2: ctrl=%0h while invalid, required 0", o2_ctrl);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0);
        stall = 1'b0;
        flush = 1'b0;
        rst   = 1'b1;
        step();
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b1, 3'b111, 69'h5);
        step();
        step();
        n_cmp = n_cmp + 1;
        if (o2_valid !== 1'b1 || o2_ctrl !== 3'b111) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_preload: valid=%b ctrl=%0h, required 1/7", o2_valid, o2_ctrl);
        end
        #3 rst = 1'b1;
        #1;
        n_cmp = n_cmp + 1;
        if (o1_valid !== 1'b0 || o1_ctrl !== '0 || o1_data !== '0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_async_u1: v=%b c=%0h d=%0h, required 0/0/0", o1_valid, o1_ctrl, o1_data);
        end
        n_cmp = n_cmp + 1;
        if (o2_valid !== 1'b0 || o2_ctrl !== '0 || o2_data !== '0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_async_u2: v=%b c=%0h d=%0h, required 0/0/0", o2_valid, o2_ctrl, o2_data);
        end
`ifdef PIPE_STAGE_STATS_EN
        n_cmp = n_cmp + 1;
        if (s1_cnt !== 4'd0 || b1_cnt !== 4'd0 || s2_cnt !== 16'd0 || b2_cnt !== 16'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_counters: %0d %0d %0d %0d, required all 0", s1_cnt, b1_cnt, s2_cnt, b2_cnt);
        end
`endif
        #2 rst = 1'b0;
        step();
        n_cmp = n_cmp + 1;
        if (o1_valid !== 1'b1 || o2_valid !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_release_edge1: u1=%b u2=%b, required 1/0", o1_valid, o2_valid);
        end
        step();
        n_cmp = n_cmp + 1;
        if (o2_valid !== 1'b1 || o2_ctrl !== 3'b111 || o2_data !== 69'h5) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_release_edge2: v=%b c=%0h d=%0h, required 1/7/5", o2_valid, o2_ctrl, o2_data);
        end
    endtask

    task automatic test_streaming();
        logic [CW-1:0] ctrls [0:2];
        ctrls[0] = 3'b001;
        ctrls[1] = 3'b010;
        ctrls[2] = 3'b110;
        do_reset();
        drive(1'b1, ctrls[0], 69'd1);
        step();
        n_cmp = n_cmp + 1;
        if (o1_data !== 69'd1 || o2_valid !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL stream_first: u1 d=%0h u2 v=%b, required 1/0", o1_data, o2_valid);
        end
        for (int i = 1; i <= 3; i++) begin
            if (i < 3) drive(1'b1, ctrls[i], 69'(i + 1));
            else       drive(1'b0, 3'b000, 69'd0);
            step();
            n_cmp = n_cmp + 1;
            if (o2_valid !== 1'b1 || o2_data !== 69'(i) || o2_ctrl !== ctrls[i-1]) begin
                n_fail = n_fail + 1;
                $display("FAIL stream_%0d: v=%b d=%0h c=%0h, required 1/%0h/%0h",
                         i, o2_valid, o2_data, o2_ctrl, i, ctrls[i-1]);
            end
        end
        step();
        n_cmp = n_cmp + 1;
        if (o2_valid !== 1'b0 || o2_ctrl !== '0) begin
            n_fail = n_fail + 1;
            $display("FAIL stream_drain: v=%b c=%0h, required 0/0", o2_valid, o2_ctrl);
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1'b1, 3'b101, 69'hA);
        step();
        drive(1'b1, 3'b011, 69'hB);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp = n_cmp + 1;
            if (o1_valid !== 1'b1 || o1_data !== 69'hA || o1_ctrl !== 3'b101) begin
                n_fail = n_fail + 1;
                $display("FAIL stall_hold_%0d: v=%b d=%0h c=%0h, required 1/a/5", i, o1_valid, o1_data, o1_ctrl);
            end
        end
        stall = 1'b0;
        step();
        n_cmp = n_cmp + 1;
        if (o1_data !== 69'hB || o1_ctrl !== 3'b011) begin
            n_fail = n_fail + 1;
            $display("FAIL stall_release: d=%0h c=%0h, required b/3", o1_data, o1_ctrl);
        end
`ifdef PIPE_STAGE_STATS_EN
        n_cmp = n_cmp + 1;
        if (s1_cnt !== 4'd3 || s2_cnt !== 16'd3) begin
            n_fail = n_fail + 1;
            $display("FAIL stall_count: u1=%0d u2=%0d, required 3/3", s1_cnt, s2_cnt);
        end
`endif
    endtask

    task automatic test_flush_during_stall();
        do_reset();
        drive(1'b1, 3'b101, 69'h33);
        step();
        step();
        stall = 1'b1;
        flush = 1'b1;
        step();
        stall = 1'b0;
        flush = 1'b0;
        n_cmp = n_cmp + 1;
        if (o1_valid !== 1'b0 || o1_ctrl !== '0 || o1_data !== 69'h33) begin
            n_fail = n_fail + 1;
            $display("FAIL flush_u1: v=%b c=%0h d=%0h, required 0/0/33", o1_valid, o1_ctrl, o1_data);
        end
        n_cmp = n_cmp + 1;
        if (o2_valid !== 1'b0 || o2_ctrl !== '0) begin
            n_fail = n_fail + 1;
            $display("FAIL flush_u2: v=%b c=%0h, required 0/0", o2_valid, o2_ctrl);
        end
`ifdef PIPE_STAGE_STATS_EN
        // u2 already saw one bubble on the first edge after reset.
        n_cmp = n_cmp + 1;
        if (s1_cnt !== 4'd0 || b1_cnt !== 4'd1 || s2_cnt !== 16'd0 || b2_cnt !== 16'd2) begin
            n_fail = n_fail + 1;
            $display("FAIL flush_counts: s1=%0d b1=%0d s2=%0d b2=%0d, required 0/1/0/2",
                     s1_cnt, b1_cnt, s2_cnt, b2_cnt);
        end
`endif
    endtask

    task automatic test_flush_pipeline();
        do_reset();
        drive(1'b1, 3'b001, 69'd1);
        step();
        drive(1'b1, 3'b010, 69'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b1, 3'b100, 69'd3);
        step();
        n_cmp = n_cmp + 1;
        if (o2_valid !== 1'b0 || o1_valid !== 1'b1 || o1_data !== 69'd3) begin
            n_fail = n_fail + 1;
            $display("FAIL flush_drop: u2 v=%b u1 v=%b d=%0h, required 0/1/3", o2_valid, o1_valid, o1_data);
        end
        drive(1'b0, 3'b000, 69'd0);
        step();
        n_cmp = n_cmp + 1;
        if (o2_valid !== 1'b1 || o2_data !== 69'd3 || o2_ctrl !== 3'b100) begin
            n_fail = n_fail + 1;
            $display("FAIL flush_refill: v=%b d=%0h c=%0h, required 1/3/4", o2_valid, o2_data, o2_ctrl);
        end
    endtask

    task automatic test_invalid_ctrl();
        do_reset();
        drive(1'b0, 3'b111, 69'h44);
        step();
        n_cmp = n_cmp + 1;
        if (o1_valid !== 1'b0 || o1_ctrl !== '0 || o1_data !== 69'h44) begin
            n_fail = n_fail + 1;
            $display("FAIL invalid_u1: v=%b c=%0h d=%0h, required 0/0/44", o1_valid, o1_ctrl, o1_data);
        end
        step();
        n_cmp = n_cmp + 1;
        if (o2_valid !== 1'b0 || o2_ctrl !== '0 || o2_data !== 69'h44) begin
            n_fail = n_fail + 1;
            $display("FAIL invalid_u2: v=%b c=%0h d=%0h, required 0/0/44", o2_valid, o2_ctrl, o2_data);
        end
`ifdef PIPE_STAGE_STATS_EN
        n_cmp = n_cmp + 1;
        if (b1_cnt !== 4'd2 || b2_cnt !== 16'd2) begin
            n_fail = n_fail + 1;
            $display("FAIL invalid_bubbles: u1=%0d u2=%0d, required 2/2", b1_cnt, b2_cnt);
        end
`endif
    endtask

    task automatic test_saturation();
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 20; i++) step();
        stall = 1'b0;
        n_cmp = n_cmp + 1;
        if (o1_valid !== 1'b0 || o2_valid !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL sat_idle: u1=%b u2=%b, required 0/0", o1_valid, o2_valid);
        end
`ifdef PIPE_STAGE_STATS_EN
        n_cmp = n_cmp + 1;
        if (s1_cnt !== 4'd15 || s2_cnt !== 16'd20) begin
            n_fail = n_fail + 1;
            $display("FAIL sat_stall: u1=%0d u2=%0d, required 15/20", s1_cnt, s2_cnt);
        end
        n_cmp = n_cmp + 1;
        if (b1_cnt !== 4'd0 || b2_cnt !== 16'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL sat_no_bubble: u1=%0d u2=%0d, required 0/0", b1_cnt, b2_cnt);
        end
`endif
    endtask

    initial begin
        #2;
        test_reset();
        test_streaming();
        test_stall();
        test_flush_during_stall();
        test_flush_pipeline();
        test_invalid_ctrl();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
